// File: rtl/mem_unit_pkg.sv
// Shared constants and helpers for the unified memory stage.
package mem_unit_pkg;

  // Default byte-address width (1 KiB of memory).
  localparam int MEM_ADDR_WIDTH = 10;

  // Control-unit strobes that drive this stage.
  typedef struct packed {
    logic memread;
    logic memwrite;
    logic iord;
    logic irwrite;
  } mem_ctrl_t;

  // Strobe encodings the control unit asserts in its memory states.
  localparam mem_ctrl_t CTRL_IDLE  = '{memread: 1'b0, memwrite: 1'b0, iord: 1'b0, irwrite: 1'b0};
  localparam mem_ctrl_t CTRL_FETCH = '{memread: 1'b1, memwrite: 1'b0, iord: 1'b0, irwrite: 1'b1};
  localparam mem_ctrl_t CTRL_LBRD  = '{memread: 1'b1, memwrite: 1'b0, iord: 1'b1, irwrite: 1'b0};
  localparam mem_ctrl_t CTRL_SBWR  = '{memread: 1'b0, memwrite: 1'b1, iord: 1'b1, irwrite: 1'b0};

  // Sign-extend a loaded byte to a full register word.
  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  // Pick byte lane n (0 = most significant) out of a big-endian word.
  function automatic logic [7:0] be_lane(input logic [31:0] w, input logic [1:0] n);
    return w[8*(3-n) +: 8];
  endfunction

endpackage

// File: rtl/mem_unit_byte_ram.sv
// Byte-organised RAM: one aligned 4-byte combinational read port,
// a 1-byte core write port and a 4-byte big-endian load write port.
// The two write ports are made mutually exclusive by the caller.
module byte_ram
  import mem_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-3:0] i_rd_widx,
  output logic [31:0]           o_rd_word,
  input  logic                  i_st_we,
  input  logic [ADDR_WIDTH-1:0] i_st_addr,
  input  logic [7:0]            i_st_byte,
  input  logic                  i_ld_we,
  input  logic [ADDR_WIDTH-3:0] i_ld_widx,
  input  logic [31:0]           i_ld_word
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [7:0] r_mem [DEPTH];

  // Big-endian word read: lowest address lands in the top byte.
  always_comb begin
    o_rd_word = {r_mem[{i_rd_widx, 2'd0}], r_mem[{i_rd_widx, 2'd1}],
                 r_mem[{i_rd_widx, 2'd2}], r_mem[{i_rd_widx, 2'd3}]};
  end

  // Writes; contents are deliberately not reset so a preload survives reset.
  always_ff @(posedge clk) begin
    if (i_ld_we) begin
      r_mem[{i_ld_widx, 2'd0}] <= i_ld_word[31:24];
      r_mem[{i_ld_widx, 2'd1}] <= i_ld_word[23:16];
      r_mem[{i_ld_widx, 2'd2}] <= i_ld_word[15:8];
      r_mem[{i_ld_widx, 2'd3}] <= i_ld_word[7:0];
    end
    if (i_st_we)
      r_mem[i_st_addr] <= i_st_byte;
  end

endmodule

// File: rtl/mem_unit.sv
// Unified instruction/data memory stage: address mux, IR, MDR with byte
// sign extension, sticky misaligned-fetch flag and load-port arbitration.
module mem_unit
  import mem_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           aluout_i,
  input  logic [31:0]           wdata_i,
  input  logic                  memread_i,
  input  logic                  memwrite_i,
  input  logic                  iord_i,
  input  logic                  irwrite_i,
  output logic [31:0]           ir_o,
  output logic [31:0]           mdr_o,
  output logic                  fetch_err_o,
  input  logic                  ld_valid_i,
  input  logic [ADDR_WIDTH-3:0] ld_addr_i,
  input  logic [31:0]           ld_data_i,
  output logic                  ld_ready_o
);

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [31:0]           w_word;
  logic [7:0]            w_byte;
  logic                  w_st;
  logic                  w_ld_we;
  logic                  w_ir_ld;
  logic                  w_mdr_ld;
  logic [31:0]           r_ir;
  logic [31:0]           r_mdr;
  logic                  r_err;

  // Address select, truncation gives the wrap modulo memory size.
  always_comb begin
    w_addr = iord_i ? aluout_i[ADDR_WIDTH-1:0] : pc_i[ADDR_WIDTH-1:0];
    w_byte = be_lane(w_word, w_addr[1:0]);
  end

  // A core store owns the write side this cycle; the load port waits.
  always_comb begin
    w_st       = memwrite_i & iord_i;
    ld_ready_o = ~w_st;
    w_ld_we    = ld_valid_i & ~w_st;
    w_ir_ld    = irwrite_i & memread_i & ~iord_i;
    w_mdr_ld   = memread_i & iord_i;
  end

  byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk       (clk),
    .i_rd_widx (w_addr[ADDR_WIDTH-1:2]),
    .o_rd_word (w_word),
    .i_st_we   (w_st),
    .i_st_addr (aluout_i[ADDR_WIDTH-1:0]),
    .i_st_byte (wdata_i[7:0]),
    .i_ld_we   (w_ld_we),
    .i_ld_widx (ld_addr_i),
    .i_ld_word (ld_data_i)
  );

  // IR / MDR capture and sticky fetch-error flag; reset drops any capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir  <= '0;
      r_mdr <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_ir_ld) begin
        r_ir <= w_word;
        if (pc_i[1:0] != 2'b00)
          r_err <= 1'b1;
      end
      if (w_mdr_ld)
        r_mdr <= sext8(w_byte);
    end
  end

  assign ir_o        = r_ir;
  assign mdr_o       = r_mdr;
  assign fetch_err_o = r_err;

endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit: directed scenarios followed by random traffic,
// all compared against a byte-array reference model.
module tb_mem_unit;

  localparam int AW   = 10;
  localparam int SIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pc_i, aluout_i, wdata_i;
  logic          memread_i, memwrite_i, iord_i, irwrite_i;
  logic [31:0]   ir_o, mdr_o;
  logic          fetch_err_o;
  logic          ld_valid_i;
  logic [AW-3:0] ld_addr_i;
  logic [31:0]   ld_data_i;
  logic          ld_ready_o;

  mem_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .aluout_i(aluout_i), .wdata_i(wdata_i),
    .memread_i(memread_i), .memwrite_i(memwrite_i), .iord_i(iord_i),
    .irwrite_i(irwrite_i), .ir_o(ir_o), .mdr_o(mdr_o), .fetch_err_o(fetch_err_o),
    .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
    .ld_ready_o(ld_ready_o)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [7:0]  m_mem [SIZE];
  logic [31:0] m_ir, m_mdr;
  logic        m_err;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_word(input int a);
    int b;
    b = (a % SIZE) & ~3;
    return {m_mem[b], m_mem[b+1], m_mem[b+2], m_mem[b+3]};
  endfunction

  // One clock: drive inputs, check ready, advance model, check registers.
  task automatic step(input logic r, input logic rd, input logic wr, input logic io,
                      input logic irw, input logic [31:0] pc, input logic [31:0] alu,
                      input logic [31:0] wd, input logic lv, input logic [AW-3:0] la,
                      input logic [31:0] ld);
    int          addr;
    logic        store, ready;
    logic [31:0] nir, nmdr;
    logic        nerr;
    rst = r; memread_i = rd; memwrite_i = wr; iord_i = io; irwrite_i = irw;
    pc_i = pc; aluout_i = alu; wdata_i = wd;
    ld_valid_i = lv; ld_addr_i = la; ld_data_i = ld;
    #1;
    store = wr && io;
    ready = !store;
    chk("ld_ready", {31'd0, ld_ready_o}, {31'd0, ready});
    addr = io ? int'(alu % SIZE) : int'(pc % SIZE);
    nir = m_ir; nmdr = m_mdr; nerr = m_err;
    if (r) begin
      nir = 0; nmdr = 0; nerr = 0;
    end else begin
      if (irw && rd && !io) begin
        nir = m_word(addr);
        if (pc % 4 != 0) nerr = 1;
      end
      if (rd && io)
        nmdr = 32'(signed'(m_mem[addr]));
    end
    @(posedge clk);
    m_ir = nir; m_mdr = nmdr; m_err = nerr;
    if (store) m_mem[alu % SIZE] = wd[7:0];
    if (lv && ready)
      for (int k = 0; k < 4; k++) m_mem[int'(la) * 4 + k] = ld[31 - 8*k -: 8];
    #1;
    chk("ir", ir_o, m_ir);
    chk("mdr", mdr_o, m_mdr);
    chk("fetch_err", {31'd0, fetch_err_o}, {31'd0, m_err});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] w;
    m_ir = 0; m_mdr = 0; m_err = 0;
    for (int i = 0; i < SIZE; i++) m_mem[i] = 8'h00;
    rst = 1; memread_i = 0; memwrite_i = 0; iord_i = 0; irwrite_i = 0;
    pc_i = 0; aluout_i = 0; wdata_i = 0; ld_valid_i = 0; ld_addr_i = 0; ld_data_i = 0;
    @(posedge clk); #1;
    chk("rst_ir", ir_o, 32'h0);
    chk("rst_mdr", mdr_o, 32'h0);
    chk("rst_err", {31'd0, fetch_err_o}, 32'h0);

    // Preload the whole memory through the load port while in reset.
    for (int i = 0; i < SIZE / 4; i++) begin
      w = (i == 0) ? 32'h20080005 : $urandom;
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, (AW-2)'(i), w);
    end

    // Fetch of the preloaded instruction.
    step(0, 1, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0);
    chk("fetch0_const", ir_o, 32'h20080005);
    chk("fetch0_mdr", mdr_o, 32'h0);

    // Signed byte loads.
    step(0, 0, 1, 1, 0, 0, 32'h103, 32'h80, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 32'h103, 0, 0, 0, 0);
    chk("lb_neg", mdr_o, 32'hFFFFFF80);
    step(0, 0, 1, 1, 0, 0, 32'h103, 32'h7F, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 32'h103, 0, 0, 0, 0);
    chk("lb_pos", mdr_o, 32'h0000007F);

    // Byte store then fetch the containing word.
    step(0, 0, 1, 1, 0, 0, 32'h102, 32'h123456AB, 0, 0, 0);
    step(0, 1, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0);
    chk("sb_lane2", {24'd0, ir_o[15:8]}, 32'hAB);

    // Store collides with a load-port request; load goes the cycle after.
    step(0, 0, 1, 1, 0, 0, 32'h200, 32'h55, 1, 8'h81, 32'h11223344);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h81, 32'h11223344);
    step(0, 1, 0, 0, 1, 32'h200, 0, 0, 0, 0, 0);
    chk("coll_store", {24'd0, ir_o[31:24]}, 32'h55);
    step(0, 1, 0, 0, 1, 32'h204, 0, 0, 0, 0, 0);
    chk("coll_load", ir_o, 32'h11223344);

    // Read concurrent with a load write to the same word sees old data.
    step(0, 1, 0, 0, 1, 32'h204, 0, 0, 1, 8'h81, 32'hCAFEF00D);
    chk("no_fwd", ir_o, 32'h11223344);
    // Read concurrent with a store to the same byte sees old byte.
    step(0, 1, 1, 1, 0, 0, 32'h200, 32'hEE, 0, 0, 0);
    chk("rd_old", mdr_o, 32'h00000055);

    // Misaligned fetch: aligned word, sticky flag.
    step(0, 1, 0, 0, 1, 32'h6, 0, 0, 0, 0, 0);
    idle();
    step(0, 1, 0, 0, 1, 32'h0, 0, 0, 0, 0, 0);
    chk("err_sticky", {31'd0, fetch_err_o}, 32'h1);
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("err_cleared", {31'd0, fetch_err_o}, 32'h0);

    // Address wrap.
    step(0, 1, 0, 1, 0, 0, 32'h400, 0, 0, 0, 0);
    chk("wrap", mdr_o, 32'h00000020);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
           (AW-2)'($urandom), $urandom);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
